// File: rtl/window_peak_tracker_pkg.sv
// Shared definitions for window_peak_tracker.
//   state_t     : FSM encoding (EMPTY / ACCUM / HOLD)
//   DEF_WIDTH   : default sample width (multiple of 4)
//   DEF_WINDOW  : default number of accepted samples per window
package window_peak_tracker_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ACCUM = 2'b01,
      HOLD  = 2'b10
   } state_t;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_WINDOW = 16;

endpackage

// File: rtl/window_peak_tracker_if.sv
// Stream bundle for window_peak_tracker.
//   clear                       : synchronous window abort (master -> slave)
//   in_valid/in_data/in_ready   : sample stream into the tracker
//   out_valid/out_ready         : window result handshake
//   out_max/out_min/out_max_hits: window result payload
// master = producer/consumer side (bench), slave = tracker side.
interface window_peak_tracker_if
   import window_peak_tracker_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(DEF_WINDOW + 1)
);
   logic             clear;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_max;
   logic [WIDTH-1:0] out_min;
   logic [CNT_W-1:0] out_max_hits;

   modport master (
      output clear, in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_max, out_min, out_max_hits
   );

   modport slave (
      input  clear, in_valid, in_data, out_ready,
      output in_ready, out_valid, out_max, out_min, out_max_hits
   );
endinterface

// File: rtl/window_peak_tracker_mag_comp_w.sv
// mag_comp_w: WIDTH-bit unsigned magnitude comparator assembled from 4-bit
// slices chained MSB-first.
//   a, b : unsigned operands
//   gt   : a > b
//   lt   : a < b
//   eq   : a == b
module mag_comp_w #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             gt,
   output logic             lt,
   output logic             eq
);
   localparam int NS = WIDTH / 4;

   logic [NS-1:0] s_gt, s_lt, s_eq;
   // c_*[i] is the verdict over slices NS-1 down to i; c_*[NS] seeds the
   // chain as "everything above is equal".
   logic [NS:0]   c_gt, c_lt, c_eq;

   assign c_gt[NS] = 1'b0;
   assign c_lt[NS] = 1'b0;
   assign c_eq[NS] = 1'b1;

   for (genvar i = 0; i < NS; i++) begin : g_slice
      assign s_gt[i] = a[4*i +: 4] > b[4*i +: 4];
      assign s_lt[i] = a[4*i +: 4] < b[4*i +: 4];
      assign s_eq[i] = a[4*i +: 4] == b[4*i +: 4];

      // Upper part decides unless it is equal, then this slice decides.
      assign c_gt[i] = c_gt[i+1] | (c_eq[i+1] & s_gt[i]);
      assign c_lt[i] = c_lt[i+1] | (c_eq[i+1] & s_lt[i]);
      assign c_eq[i] = c_eq[i+1] & s_eq[i];
   end

   assign gt = c_gt[0];
   assign lt = c_lt[0];
   assign eq = c_eq[0];
endmodule

// File: rtl/window_peak_tracker.sv
// window_peak_tracker: streaming min/max accumulator over fixed windows.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : clear, sample stream in, window result out
// After WINDOW accepted samples the block holds max, min and the number of
// samples equal to max on the output port until the consumer takes them.
module window_peak_tracker
   import window_peak_tracker_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int WINDOW = DEF_WINDOW,
   parameter int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic                  clock,
   input  logic                  reset,
   window_peak_tracker_if.slave  bus
);
   state_t           st, st_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [CNT_W-1:0] hits, hits_nx;
   logic [WIDTH-1:0] max_r, max_nx;
   logic [WIDTH-1:0] min_r, min_nx;
   logic             accept;

   logic max_gt, max_lt, max_eq;
   logic min_gt, min_lt, min_eq;
   logic unused_flags;

   mag_comp_w #(.WIDTH(WIDTH)) u_cmp_max (
      .a  (bus.in_data),
      .b  (max_r),
      .gt (max_gt),
      .lt (max_lt),
      .eq (max_eq)
   );

   mag_comp_w #(.WIDTH(WIDTH)) u_cmp_min (
      .a  (bus.in_data),
      .b  (min_r),
      .gt (min_gt),
      .lt (min_lt),
      .eq (min_eq)
   );

   // Flags not needed for the update decision.
   assign unused_flags = &{max_lt, min_gt, min_eq};

   // in_ready comes from the state register only.
   assign bus.in_ready     = (st != HOLD);
   assign bus.out_valid    = (st == HOLD);
   assign bus.out_max      = max_r;
   assign bus.out_min      = min_r;
   assign bus.out_max_hits = hits;

   assign accept = bus.in_valid & (st != HOLD);

   always_comb begin
      st_nx   = st;
      cnt_nx  = cnt;
      hits_nx = hits;
      max_nx  = max_r;
      min_nx  = min_r;
      case (st)
         EMPTY: begin
            if (accept) begin
               max_nx  = bus.in_data;
               min_nx  = bus.in_data;
               hits_nx = CNT_W'(1);
               cnt_nx  = CNT_W'(1);
               st_nx   = (WINDOW == 1) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               if (max_gt) begin
                  max_nx  = bus.in_data;
                  hits_nx = CNT_W'(1);
               end else if (max_eq) begin
                  hits_nx = hits + CNT_W'(1);
               end
               if (min_lt)
                  min_nx = bus.in_data;
               cnt_nx = cnt + CNT_W'(1);
               if (cnt_nx == CNT_W'(WINDOW))
                  st_nx = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               st_nx   = EMPTY;
               cnt_nx  = '0;
               hits_nx = '0;
            end
         end
         default: st_nx = EMPTY;
      endcase
      // Abort wins over any accept or output handshake this cycle.
      if (bus.clear) begin
         st_nx   = EMPTY;
         cnt_nx  = '0;
         hits_nx = '0;
         max_nx  = '0;
         min_nx  = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st    <= EMPTY;
         cnt   <= '0;
         hits  <= '0;
         max_r <= '0;
         min_r <= '0;
      end else begin
         st    <= st_nx;
         cnt   <= cnt_nx;
         hits  <= hits_nx;
         max_r <= max_nx;
         min_r <= min_nx;
      end
   end
endmodule

// File: tb/tb_window_peak_tracker.sv
// Scoreboard bench for window_peak_tracker (WIDTH=4, WINDOW=4).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge. A behavioural model pushes the expected window result
// on the sample that completes a window; a monitor pops on each handshake.
module tb_window_peak_tracker;
   localparam int WIDTH  = 4;
   localparam int WINDOW = 4;
   localparam int CNT_W  = 3;

   typedef struct {
      logic [WIDTH-1:0] mx;
      logic [WIDTH-1:0] mn;
      logic [CNT_W-1:0] hits;
   } res_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   res_t q[$];

   int               m_cnt  = 0;
   logic [WIDTH-1:0] m_max  = '0;
   logic [WIDTH-1:0] m_min  = '0;
   logic [CNT_W-1:0] m_hits = '0;

   window_peak_tracker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   window_peak_tracker #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt  = 0;
      m_max  = '0;
      m_min  = '0;
      m_hits = '0;
   endtask

   task automatic model_accept(input logic [WIDTH-1:0] s);
      res_t r;
      if (m_cnt == 0) begin
         m_max  = s;
         m_min  = s;
         m_hits = 1;
      end else begin
         if (s > m_max) begin
            m_max  = s;
            m_hits = 1;
         end else if (s == m_max) begin
            m_hits = m_hits + 1;
         end
         if (s < m_min) m_min = s;
      end
      m_cnt++;
      if (m_cnt == WINDOW) begin
         r.mx = m_max; r.mn = m_min; r.hits = m_hits;
         q.push_back(r);
         model_reset();
      end
   endtask

   // Called in the drive phase; leaves in_valid high for back-to-back use.
   task automatic send(input logic [WIDTH-1:0] s);
      bit done = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = s;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clock);
         if (bus.in_ready) begin
            model_accept(s);
            done = 1;
         end
         @(posedge clock);
         #1;
      end
      if (!done) chk("send_timeout", 0, 1);
   endtask

   task automatic idle();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) begin
         @(posedge clock);
         #1;
      end
      chk("drain", q.size(), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_max"},   bus.out_max, 0);
      chk({tag, "_min"},   bus.out_min, 0);
      chk({tag, "_hits"},  bus.out_max_hits, 0);
      chk({tag, "_ovld"},  bus.out_valid, 0);
      chk({tag, "_irdy"},  bus.in_ready, 1);
   endtask

   // Result monitor: a handshake completes on the next rising edge.
   always @(negedge clock) begin
      res_t r;
      if (reset && bus.out_valid && bus.out_ready && !bus.clear) begin
         if (q.size() == 0) begin
            chk("sb_unexpected", 1, 0);
         end else begin
            r = q.pop_front();
            chk("res_max",  bus.out_max, r.mx);
            chk("res_min",  bus.out_min, r.mn);
            chk("res_hits", bus.out_max_hits, r.hits);
         end
      end
   end

   initial begin
      res_t hold_exp;
      bus.clear     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1 reset = 1'b1;
      @(negedge clock);
      chk_zero("rst");
      @(posedge clock); #1;

      // Basic window plus result latency.
      send(5); send(9); send(2); send(9); idle();
      @(negedge clock);
      chk("lat_ovld", bus.out_valid, 1);
      @(posedge clock); #1;
      drain();

      // Extremes and an all-equal window.
      send(0); send(15); send(15); send(0); idle();
      drain();
      send(7); send(7); send(7); send(7); idle();
      drain();

      // Backpressure: result held while the producer keeps pushing.
      bus.out_ready = 1'b0;
      send(11); send(3); send(11); send(6);
      hold_exp = q[0];
      bus.in_data = 4'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         chk("bp_irdy", bus.in_ready, 0);
         chk("bp_ovld", bus.out_valid, 1);
         chk("bp_max",  bus.out_max, hold_exp.mx);
         chk("bp_min",  bus.out_min, hold_exp.mn);
         chk("bp_hits", bus.out_max_hits, hold_exp.hits);
         @(posedge clock); #1;
      end
      idle();
      bus.out_ready = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      chk("bp_after_irdy", bus.in_ready, 1);
      chk("bp_after_ovld", bus.out_valid, 0);
      chk("bp_q", q.size(), 0);
      @(posedge clock); #1;
      send(1); send(2); send(3); send(4); idle();
      drain();

      // Abort after two samples.
      send(3); send(12); idle();
      bus.clear = 1'b1;
      model_reset();
      @(posedge clock); #1;
      bus.clear = 1'b0;
      @(negedge clock);
      chk_zero("clr");
      @(posedge clock); #1;
      send(4); send(6); send(5); send(8); idle();
      drain();

      // Asynchronous reset mid-window.
      send(3); send(7); idle();
      #2 reset = 1'b0;
      #1 chk_zero("arst");
      model_reset();
      @(posedge clock); #1 reset = 1'b1;
      @(negedge clock);
      chk_zero("arst_rel");
      @(posedge clock); #1;

      // clear together with out_ready in HOLD.
      bus.out_ready = 1'b0;
      send(1); send(2); send(3); send(4); idle();
      @(negedge clock);
      chk("hc_ovld", bus.out_valid, 1);
      chk("hc_max",  bus.out_max, q[0].mx);
      @(posedge clock); #1;
      bus.clear     = 1'b1;
      bus.out_ready = 1'b1;
      void'(q.pop_front());
      @(posedge clock); #1;
      bus.clear = 1'b0;
      @(negedge clock);
      chk_zero("hclr");
      chk("final_q", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/window_peak_tracker.md
# window_peak_tracker

Streaming min/max accumulator sitting directly downstream of the 4-bit structural magnitude comparator. Consumes a valid-qualified stream of unsigned samples and compares each accepted sample against the stored running maximum and minimum using two comparator instances. Uses only the comparators' greater-than, less-than and equal flags to decide register updates. After every WINDOW accepted samples it presents max, min and max-hit count on a valid/ready output port, then starts a fresh window.

## Interface
- WIDTH, 4, sample width in bits; comparator slice width, must be a multiple of 4
- WINDOW, 16, accepted samples per window, at least 1
- CNT_W, $clog2(WINDOW+1), width of the hit counter
- clock  input  1  rising-edge clock, the only clock
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous window abort
- in_valid  input  1  sample present
- in_data  input  WIDTH  unsigned sample
- in_ready  output  1  block can accept a sample
- out_valid  output  1  window result present
- out_ready  input  1  consumer takes the result
- out_max  output  WIDTH  largest sample in the window
- out_min  output  WIDTH  smallest sample in the window
- out_max_hits  output  CNT_W  number of samples equal to out_max

## Operation
- Accept: in_valid & in_ready on a rising edge. No other event consumes a sample.
- States:
  - EMPTY: no sample yet in the window.
  - ACCUM: at least one sample held.
  - HOLD: result on the output port.
- EMPTY, on accept: max and min are loaded with the sample, hits = 1, count = 1. Go to ACCUM, or to HOLD if WINDOW = 1.
- ACCUM, on accept: compare the sample against max and against min.
  - Sample > max: max takes the sample, hits = 1.
  - Sample = max: hits increments.
  - Sample < max: no change to max or hits.
  - Sample < min: min takes the sample. Otherwise min is unchanged.
  - Count increments. When count reaches WINDOW, go to HOLD.
- HOLD: in_ready = 0 and in_valid is ignored. When out_valid & out_ready, go to EMPTY and zero count and hits.
- in_ready = (state != HOLD). It is decoded from the state register only and has no path from in_valid.
- out_valid = (state == HOLD).
- clear: next state EMPTY, and count, hits, max and min are zeroed. clear overrides an accept or an out handshake in the same cycle.
- Arithmetic: all comparisons are unsigned. Hits cannot overflow because it is at most WINDOW.

## Timing
- Reset values: state EMPTY, out_max = 0, out_min = 0, out_max_hits = 0, out_valid = 0, in_ready = 1.
- Reset mid-window or in HOLD discards all data immediately (asynchronous).
- Result latency: out_valid rises on the edge that accepts the WINDOW-th sample and is visible in the following cycle.
- out_max, out_min and out_max_hits are registered and stable for the whole of HOLD.
- After the out handshake edge, in_ready = 1 in the next cycle. This gives at least one bubble between windows.
- Back-to-back accepts at one sample per cycle are supported throughout EMPTY and ACCUM.
- Outputs in EMPTY and ACCUM show the partial running values. They are meaningful only while out_valid = 1.

## Structure
- Shared package holds:
  - state encoding constants: EMPTY = 2'b00, ACCUM = 2'b01, HOLD = 2'b10
  - default WIDTH and WINDOW
- Sub-module mag_comp_w: WIDTH-bit unsigned comparator built by chaining 4-bit comparator slices MSB-first.
  - The combined greater-than is the upper slice's greater-than, or the upper slice's equal AND the lower slice's greater-than. Less-than is formed the same way.
  - Equal is the AND of all slice equals.
- Two instances of mag_comp_w:
  - sample vs max
  - sample vs min
- Top level holds the FSM, the registers and the counter.

## Test plan
- WINDOW=4, samples 5, 9, 2, 9 back-to-back → out_valid after 4th accept; out_max = 9, out_min = 2, out_max_hits = 2.
- Boundary values with WINDOW=4, samples 0, 15, 15, 0 → max 15, min 0, hits 2.
- All-equal window, samples 7, 7, 7, 7 → max 7, min 7, hits 4.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles while driving in_valid = 1 → in_ready stays 0, outputs stay stable, no sample lost or consumed.
  - Then assert out_ready → in_ready = 1 the cycle after the handshake, and the next window starts clean.
- clear after 2 of 4 samples (3, 12), then samples 4, 6, 5, 8 → result max 8, min 4, hits 1; the aborted samples have no effect.
- reset low asynchronously mid-window, then clear asserted together with out_ready in HOLD → after each event, all outputs are 0, in_ready = 1 and out_valid = 0.
